// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Single-word memory access controller in front of an internal
//               2^ADDR_W x DATA_W synchronous RAM. Inserts WAIT_STATES extra
//               cycles before the access edge and reports completion with a
//               busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 18,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              req_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_wr;
  logic              access_edge;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // The access edge is the last WAIT cycle; the RAM is touched only here.
  assign access_edge = (state == ST_WAIT) && (cnt == 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; busy/done decode directly from state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req || wr_req) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, wait counter, read data register and error pulse.
  // Write wins when both requests arrive together; the collision is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rd_data <= '0;
      req_err <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rd_req || wr_req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_wr   <= wr_req;
            cnt     <= WAIT_INIT;
            req_err <= rd_req && wr_req;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!op_wr) begin
            rd_data <= mem[addr_q];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RAM write port: contents survive reset, and a reset on the access edge
  // suppresses the commit so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && access_edge && op_wr) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl. Table of accesses with
//               expected results queued on drive and compared on done, plus
//               hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 18;
  localparam int WAIT_STATES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rd_req;
  logic              wr_req;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              req_err;

  // Free-running clock.
  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_STATES (WAIT_STATES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .req_err (req_err)
  );

  typedef struct {
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              inject;   // drive a competing write during WAIT
    logic [DATA_W-1:0] exp_rd;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] exp_rd;
    logic              exp_err;
  } sb_t;

  sb_t  sb[$];
  vec_t vec[11];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access: drive for one cycle, queue expectation, wait for done.
  task automatic run_op(input vec_t v);
    sb_t  e;
    int   lat;
    int   busy_cnt;
    logic err1;
    logic err_late;
    logic got;
    @(negedge clk);
    wr_req = v.wr;
    rd_req = v.rd;
    addr   = v.a;
    wdata  = v.d;
    e.exp_rd  = v.exp_rd;
    e.exp_err = v.exp_err;
    sb.push_back(e);
    busy_cnt = 0;
    err1     = 1'b0;
    err_late = 1'b0;
    got      = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        err1 = req_err;
        if (v.inject) begin
          wr_req = 1'b1;
          rd_req = 1'b0;
          wdata  = 18'h22222;
        end else begin
          wr_req = 1'b0;
          rd_req = 1'b0;
          addr   = 13'h1555;
          wdata  = 18'h3FFFF;
        end
      end else begin
        wr_req = 1'b0;
        rd_req = 1'b0;
        addr   = 13'h1555;
        wdata  = 18'h3FFFF;
        if (req_err) err_late = 1'b1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("rd_data", 32'(rd_data), 32'(e.exp_rd));
      check("req_err", 32'(err1), 32'(e.exp_err));
      check("latency", 32'(lat), 32'(WAIT_STATES + 2));
      check("busy_cycles", 32'(busy_cnt), 32'(WAIT_STATES + 1));
      check("req_err_width", 32'(err_late), 32'd0);
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  // Main test sequence.
  initial begin
    int   cyc;
    logic seen_done;
    vec_t rv;

    vec[0]  = '{1'b1, 1'b0, 13'h0100, 18'h2A5A5, 1'b0, 18'h00000, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 13'h0100, 18'h00000, 1'b0, 18'h2A5A5, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 13'h1FFF, 18'h3FFFF, 1'b0, 18'h2A5A5, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 13'h0000, 18'h00001, 1'b0, 18'h2A5A5, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 13'h1FFF, 18'h00000, 1'b0, 18'h3FFFF, 1'b0};
    vec[5]  = '{1'b0, 1'b1, 13'h0000, 18'h00000, 1'b0, 18'h00001, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 13'h0010, 18'h11111, 1'b1, 18'h00001, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 13'h0010, 18'h00000, 1'b0, 18'h11111, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 13'h0020, 18'h0BEEF, 1'b0, 18'h11111, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 13'h0020, 18'h00000, 1'b0, 18'h0BEEF, 1'b0};
    vec[10] = '{1'b1, 1'b0, 13'h0030, 18'h12345, 1'b0, 18'h0BEEF, 1'b0};

    rst    = 1'b1;
    addr   = '0;
    wdata  = '0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_req_err", 32'(req_err), 32'd0);

    for (int k = 0; k < 11; k++) begin
      run_op(vec[k]);
    end

    // Reset on the cycle after a write is accepted must abort it.
    @(negedge clk);
    wr_req = 1'b1;
    addr   = 13'h0030;
    wdata  = 18'h3CAFE;
    @(negedge clk);
    wr_req = 1'b0;
    check("abort_accepted", 32'(busy), 32'd1);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_rst_busy", 32'(busy), 32'd0);
    check("abort_rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    for (cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    rv = '{1'b0, 1'b1, 13'h0030, 18'h00000, 1'b0, 18'h12345, 1'b0};
    run_op(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory access controller directly downstream of the memory address register. It takes the 13-bit address driven by the MAR, plus 18-bit write data from the data path. It performs single-word reads and writes against an internal 8K x 18 synchronous RAM, inserting a programmable number of wait states. A busy/done handshake sequences the controller so that the control unit knows when read data is valid or a write has been committed.

Parameters:
ADDR_W, 13, address width; must match the MAR output width.
DATA_W, 18, data word width.
WAIT_STATES, 2, number of extra cycles before the access edge; legal range 0..15.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
addr  input  ADDR_W  access address from MAR output.
wdata  input  DATA_W  write data.
rd_req  input  1  read request; sampled only in IDLE.
wr_req  input  1  write request; sampled only in IDLE.
busy  output  1  high while an accepted request is in progress.
done  output  1  one-cycle pulse when the access completes.
rd_data  output  DATA_W  data from the most recent completed read.
req_err  output  1  one-cycle pulse when rd_req and wr_req are sampled together.

Behaviour:
- Reset, applied at any clock edge while rst=1:
  - state goes to IDLE; busy, done, req_err and rd_data all go to 0; the wait counter clears.
  - RAM contents are not cleared.
  - A reset mid-access aborts it: a write that has not yet reached its access edge is never committed, and done does not pulse.
- States:
  - IDLE: busy=0. On an edge with rd_req or wr_req high:
    - latch addr, wdata and the op;
    - load cnt=WAIT_STATES;
    - go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: busy=1.
    - If cnt!=0: decrement cnt and stay in WAIT.
    - If cnt==0, this edge is the access edge:
      - a write stores the latched wdata to RAM at the latched addr;
      - a read loads rd_data from RAM at the latched addr;
      - go to RESP.
  - RESP: busy=0, done=1 for exactly this cycle; next edge returns to IDLE.
- Latency: if a request is sampled at edge N, the access edge is N+WAIT_STATES+1 and done is high during the cycle after that edge. Total latency is WAIT_STATES+2 cycles from request to done.
- Back-to-back: a new request may be sampled at the edge leaving RESP? No. Requests are sampled only in IDLE, so the minimum request spacing is WAIT_STATES+3 cycles.
- Ignored requests: requests during WAIT or RESP are ignored and not queued. addr and wdata changes after acceptance have no effect.
- Simultaneous rd_req and wr_req in IDLE:
  - the write is performed (write priority);
  - req_err pulses high for the cycle following the sampling edge.
- rd_data holds its value until the next completed read; writes never alter it.
- Address range: all 2^ADDR_W addresses are valid with no wrap logic. Address 13'h1FFF is the last word.
- Read data: RAM reads are registered. A read of a never-written location returns the RAM's uninitialised contents; the bench writes before reading.

Test Plan:
- rst high 2 cycles mid-idle, then low -> busy=0, done=0, rd_data=18'h00000, req_err=0.
- WAIT_STATES=2: wr_req with addr=13'h0100, wdata=18'h2A5A5 for one cycle -> busy high for 3 cycles, done pulses exactly once, 4 cycles after the request edge; then rd_req at 13'h0100 -> rd_data=18'h2A5A5 with done.
- Boundary addresses: write 18'h3FFFF to 13'h1FFF and 18'h00001 to 13'h0000, then read both -> respective values returned, with no aliasing.
- Request while busy:
  - wr_req at 13'h0010 with wdata 18'h11111 is accepted;
  - a second wr_req at 13'h0010 with wdata 18'h22222 is asserted during WAIT and is ignored;
  - read 13'h0010 -> 18'h11111.
- Simultaneous request: rd_req and wr_req together at 13'h0020 with wdata 18'h0BEEF -> req_err one-cycle pulse, write performed, rd_data unchanged; a following read returns 18'h0BEEF.
- Reset mid-write:
  - with 13'h0030 previously holding 18'h12345, issue wr_req with 18'h3CAFE;
  - assert rst on the cycle after acceptance;
  - outcome: no done pulse, state IDLE, and a later read of 13'h0030 returns 18'h12345.
